// File: rtl/mskaes_svrs_host.sv
`default_nettype none
// ============================================================================
// Module      : mskaes_svrs_host
// Description : Host-side SVRS initiator for the masked AES core. Runs a batch
//               of encryptions: fetch input word, sticky-issue it to the core,
//               collect the result and forward it downstream with its index.
//               Optional result latency report: MSKAES_SVRS_HOST_LATENCY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mskaes_svrs_host #(
    parameter int DW    = 128,
    parameter int CNT_W = 16
`ifdef MSKAES_SVRS_HOST_LATENCY_EN
    ,
    parameter int LAT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [DW-1:0]    pt_data,
    output logic             core_valid_in,
    input  logic             core_in_ready,
    output logic [DW-1:0]    core_data_in,
    input  logic             core_cipher_valid,
    output logic             core_out_ready,
    input  logic [DW-1:0]    core_data_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic [CNT_W-1:0] res_index,
    output logic             trig,
    output logic             done,
    output logic             busy
`ifdef MSKAES_SVRS_HOST_LATENCY_EN
    ,
    output logic [LAT_W-1:0] res_latency
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_OUT = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    state_t           state_q;
    logic [DW-1:0]    din_q;
    logic [DW-1:0]    res_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] idx_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            rem_q   <= cmd_count;
                            idx_q   <= '0;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (pt_valid) begin
                        din_q   <= pt_data;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (core_in_ready) begin
                        state_q <= S_WAIT_OUT;
                    end
                end
                S_WAIT_OUT: begin
                    if (core_cipher_valid) begin
                        res_q   <= core_data_out;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        rem_q <= rem_q - 1'b1;
                        // Index is left on the last run so it never reaches cmd_count.
                        if (rem_q == CNT_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MSKAES_SVRS_HOST_LATENCY_EN
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] res_lat_q;
    logic [LAT_W-1:0] lat_inc;

    // Saturating increment; the capture cycle itself is counted.
    assign lat_inc = (lat_q == '1) ? lat_q : lat_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q     <= '0;
            res_lat_q <= '0;
        end else begin
            if (state_q == S_ISSUE && core_in_ready) begin
                lat_q <= '0;
            end else if (state_q == S_WAIT_OUT) begin
                lat_q <= lat_inc;
                if (core_cipher_valid) begin
                    res_lat_q <= lat_inc;
                end
            end
        end
    end

    assign res_latency = res_lat_q;
`endif

    assign cmd_ready      = (state_q == S_IDLE);
    assign pt_ready       = (state_q == S_LOAD);
    assign core_valid_in  = (state_q == S_ISSUE);
    assign core_out_ready = (state_q == S_WAIT_OUT);
    assign trig           = (state_q == S_WAIT_OUT);
    assign res_valid      = (state_q == S_DRAIN);
    assign busy           = (state_q != S_IDLE);
    assign core_data_in   = din_q;
    assign res_data       = res_q;
    assign res_index      = idx_q;
    assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mskaes_svrs_host.sv
`default_nettype none
// Testbench for mskaes_svrs_host: randomized batches against a queue-based
// reference of expected results, with a behavioural AES-core stand-in.
module tb_mskaes_svrs_host;
    localparam int DW    = 128;
    localparam int CNT_W = 16;
    localparam int LAT_W = 8;
    localparam logic [DW-1:0] KEY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             pt_valid = 1'b0;
    logic             pt_ready;
    logic [DW-1:0]    pt_data = '0;
    logic             core_valid_in;
    logic             core_in_ready = 1'b0;
    logic [DW-1:0]    core_data_in;
    logic             core_cipher_valid = 1'b0;
    logic             core_out_ready;
    logic [DW-1:0]    core_data_out = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [DW-1:0]    res_data;
    logic [CNT_W-1:0] res_index;
    logic             trig;
    logic             done;
    logic             busy;
`ifdef MSKAES_SVRS_HOST_LATENCY_EN
    logic [LAT_W-1:0] res_latency;
`endif

    mskaes_svrs_host dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .core_valid_in(core_valid_in), .core_in_ready(core_in_ready),
        .core_data_in(core_data_in), .core_cipher_valid(core_cipher_valid),
        .core_out_ready(core_out_ready), .core_data_out(core_data_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_index(res_index), .trig(trig), .done(done), .busy(busy)
`ifdef MSKAES_SVRS_HOST_LATENCY_EN
        , .res_latency(res_latency)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    data;
        logic [CNT_W-1:0] idx;
        int               lat;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] pt_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int lat_cfg = 46;
    int p_in = 100, p_pt = 100, p_res = 100;
    bit hold_in = 0, hold_res = 0;

    int cyc = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -1, in_hs_cnt = 0;
    bit seen_pt_ready = 0, seen_cvi = 0, seen_rv = 0, seen_busy = 0;
    bit s_hs_in = 0, s_hs_out = 0, s_hs_pt = 0;
    logic [DW-1:0] s_din = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Stand-in for the AES core transformation.
    function automatic logic [DW-1:0] core_f(input logic [DW-1:0] x);
        return {x[DW-9:0], x[DW-1:DW-8]} ^ KEY;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: samples at the falling edge; a valid&ready seen here completes
    // on the following rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            s_hs_in  = core_valid_in && core_in_ready;
            s_hs_out = core_cipher_valid && core_out_ready;
            s_hs_pt  = pt_valid && pt_ready;
            s_din    = core_data_in;
            if (rst_n) begin
                if (s_hs_in) in_hs_cnt++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                seen_pt_ready |= pt_ready;
                seen_cvi      |= core_valid_in;
                seen_rv       |= res_valid;
                seen_busy     |= busy;
                if (res_valid && res_ready) begin
                    last_hs_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        check("res_unexpected", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_index", res_index, e.idx);
`ifdef MSKAES_SVRS_HOST_LATENCY_EN
                        check("res_latency", res_latency, LAT_W'(e.lat));
`endif
                    end
                end
            end
        end
    end

    // Upstream source, core model and downstream sink, driven after each rising edge.
    initial begin : bfm
        int rem;
        logic [DW-1:0] cbuf;
        rem = 0;
        cbuf = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rem = 0;
                core_in_ready = 0;
                core_cipher_valid = 0;
                pt_valid = 0;
                res_ready = 0;
            end else begin
                if (s_hs_pt && pt_q.size() > 0) void'(pt_q.pop_front());
                if (s_hs_out) core_cipher_valid = 0;
                if (s_hs_in) begin
                    cbuf = core_f(s_din);
                    rem = lat_cfg;
                end else if (rem > 0) begin
                    rem--;
                end
                if (rem == 1 && !core_cipher_valid) begin
                    core_cipher_valid = 1;
                    core_data_out = cbuf;
                end
                core_in_ready = !hold_in && rem == 0 && !core_cipher_valid &&
                                ($urandom_range(99) < p_in);
                pt_valid = (pt_q.size() > 0) && ($urandom_range(99) < p_pt);
                pt_data  = (pt_q.size() > 0) ? pt_q[0] : '0;
                res_ready = !hold_res && ($urandom_range(99) < p_res);
            end
        end
    end

    task automatic push_batch(input int n, input int lat, input bit fixed);
        exp_t e;
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = fixed ? DW'(k + 1) : {$urandom, $urandom, $urandom, $urandom};
            pt_q.push_back(w);
            e.data = core_f(w);
            e.idx  = CNT_W'(k);
            e.lat  = (lat > 255) ? 255 : lat;
            sb_q.push_back(e);
        end
    endtask

    task automatic send_cmd(input int n);
        @(posedge clk);
        #1;
        cmd_valid = 1;
        cmd_count = CNT_W'(n);
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic run_batch(input int n, input int lat, input bit fixed);
        int d0, t;
        tick();
        check("cmd_ready_before", cmd_ready, 1);
        lat_cfg = lat;
        push_batch(n, lat, fixed);
        d0 = done_cnt;
        send_cmd(n);
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            tick();
            t++;
        end
        tick();
        tick();
        check("done_count", done_cnt - d0, 1);
        if (n > 0) check("done_timing", done_cyc, last_hs_cyc + 1);
        check("sb_empty", sb_q.size(), 0);
        check("cmd_ready_after", cmd_ready, 1);
    endtask

    initial begin : main
        logic [DW-1:0]    hd;
        logic [CNT_W-1:0] hi;
        int base, t, d0;

        #3;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pt_ready", pt_ready, 0);
        check("rst_core_valid_in", core_valid_in, 0);
        check("rst_core_out_ready", core_out_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_trig", trig, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_index", res_index, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1;

        // Three fixed words through a 46-cycle core
        run_batch(3, 46, 1);

        // Empty batch
        tick();
        seen_pt_ready = 0; seen_cvi = 0; seen_rv = 0; seen_busy = 0;
        run_batch(0, 5, 0);
        check("zero_pt_ready", seen_pt_ready, 0);
        check("zero_core_valid_in", seen_cvi, 0);
        check("zero_res_valid", seen_rv, 0);
        check("zero_busy", seen_busy, 0);

        // Core stalls the input handshake
        tick();
        hold_in = 1;
        base = in_hs_cnt;
        fork
            run_batch(1, 5, 0);
            begin
                t = 0;
                while (!core_valid_in && t < 200) begin tick(); t++; end
                check("issue_seen", core_valid_in, 1);
                hd = core_data_in;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    check("issue_valid_held", core_valid_in, 1);
                    check("issue_data_held", core_data_in, hd);
                end
                hold_in = 0;
            end
        join
        check("issue_handshakes", in_hs_cnt - base, 1);

        // Downstream stalls in DRAIN
        tick();
        hold_res = 1;
        fork
            run_batch(2, 7, 0);
            begin
                t = 0;
                while (!res_valid && t < 200) begin tick(); t++; end
                check("drain_seen", res_valid, 1);
                hd = res_data;
                hi = res_index;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    check("drain_valid_held", res_valid, 1);
                    check("drain_data_held", res_data, hd);
                    check("drain_index_held", res_index, hi);
                    check("drain_pt_ready", pt_ready, 0);
                    check("drain_core_out_ready", core_out_ready, 0);
                end
                hold_res = 0;
            end
        join

        // Asynchronous reset while waiting on the core
        tick();
        lat_cfg = 30;
        push_batch(2, 30, 0);
        send_cmd(2);
        t = 0;
        while (!trig && t < 200) begin tick(); t++; end
        check("wait_out_seen", trig, 1);
        @(negedge clk);
        #2;
        d0 = done_cnt;
        rst_n = 0;
        #1;
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_trig", trig, 0);
        check("arst_busy", busy, 0);
        check("arst_core_out_ready", core_out_ready, 0);
        check("arst_res_index", res_index, 0);
        sb_q.delete();
        pt_q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        tick();
        check("arst_no_done", done_cnt - d0, 0);
        run_batch(1, 10, 0);

        // Randomized batches
        for (int r = 0; r < 6; r++) begin
            p_in  = $urandom_range(100, 30);
            p_pt  = $urandom_range(100, 30);
            p_res = $urandom_range(100, 30);
            run_batch($urandom_range(6, 1), $urandom_range(20, 1), 0);
        end
        p_in = 100; p_pt = 100; p_res = 100;

`ifdef MSKAES_SVRS_HOST_LATENCY_EN
        run_batch(1, 46, 0);
        run_batch(1, 300, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mskaes_svrs_host.md
Name: mskaes_svrs_host

Overview:
- Host-side initiator for the masked AES core's SVRS interface: the producer on the core's input channel and the consumer on its output channel.
- Accepts a batch command (N encryptions). For each run it fetches one input word from upstream, presents it to the core with sticky valid/data, and fetches the core's result.
- Forwards each result downstream with a run index and drives a scope trigger while the core computes.
- Sits between the trace-acquisition controller / input FIFO and the AES core.

Parameters:
- DW, 128, width of data words to/from the core (masked shares concatenated).
- CNT_W, 16, width of batch count and run index.
- LAT_W, 8, width of latency report; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  batch command valid.
- cmd_ready  out  1  host idle and ready for a command.
- cmd_count  in  CNT_W  number of runs in the batch; 0 is legal.
- pt_valid  in  1  upstream input word valid.
- pt_ready  out  1  host fetching an input word.
- pt_data  in  DW  upstream input word.
- core_valid_in  out  1  SVRS input valid to core.
- core_in_ready  in  1  core input ready.
- core_data_in  out  DW  data to core; held while core_valid_in is high.
- core_cipher_valid  in  1  core output valid.
- core_out_ready  out  1  host accepts core output.
- core_data_out  in  DW  core output data.
- res_valid  out  1  result valid downstream.
- res_ready  in  1  downstream accepts result.
- res_data  out  DW  captured core output.
- res_index  out  CNT_W  run index of res_data, 0-based.
- trig  out  1  high while waiting on the core.
- done  out  1  one-cycle pulse at batch completion.
- busy  out  1  state != IDLE.

Behaviour:
- No combinational path from any input to any output. Outputs are registers or decodes of the state register only.
- Reset (rst_n=0, takes effect immediately):
  - State goes to IDLE; all data, count and index registers clear.
  - cmd_ready=1; every other output is 0.
  - Reset mid-batch aborts the batch with no done pulse; the core is reset on the same net.
- FSM states: IDLE, LOAD, ISSUE, WAIT_OUT, DRAIN.
- IDLE: cmd_ready=1.
  - cmd_valid with cmd_count=0: stay in IDLE; done=1 the next cycle.
  - cmd_valid with cmd_count≠0: latch remaining=cmd_count, index=0, go to LOAD.
- LOAD: pt_ready=1.
  - On pt_valid, latch pt_data into the core_data_in register and go to ISSUE.
- ISSUE: core_valid_in=1.
  - core_data_in and core_valid_in stay constant until a cycle with core_in_ready=1 (SVRS sticky rule); then go to WAIT_OUT.
  - The host never deasserts core_valid_in before the handshake completes.
- WAIT_OUT: core_out_ready=1, trig=1.
  - On core_cipher_valid, capture core_data_out into res_data and go to DRAIN. The fetch completes in that same cycle.
- DRAIN: res_valid=1; res_data and res_index are stable.
  - On res_ready: remaining decrements and index increments.
  - If remaining was 1: go to IDLE, done=1 the next cycle.
  - Otherwise: go to LOAD.
- Ignored events:
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
  - core_cipher_valid outside WAIT_OUT is ignored (core_out_ready=0).
  - pt_valid outside LOAD is ignored.
- Index range: index never exceeds cmd_count-1, so there is no wrap-around. Maximum batch is 2^CNT_W-1 runs.
- Per-run overhead:
  - 1 cycle in LOAD when pt_valid is already high.
  - ≥1 cycle in ISSUE.
  - 1 cycle in DRAIN when res_ready is already high.

Optional Feature:
- Macro: MSKAES_SVRS_HOST_LATENCY_EN.
- With the macro defined:
  - Adds output port res_latency (LAT_W bits).
  - The counter clears on the input handshake cycle and increments every WAIT_OUT cycle, including the capture cycle; it saturates at all-ones.
  - The value is latched with res_data. A core asserting cipher_valid N cycles after the handshake yields res_latency=N.
  - Cleared by reset.
- Without the macro: no port, no counter, no other behavioural change.

Test Plan:
- Reset, cmd_count=3, pt_data=1,2,3 always valid, core model with 46-cycle latency, res_ready=1 -> three results with res_index 0,1,2 and matching data; done pulses once the cycle after the third res handshake; cmd_ready=1 thereafter.
- cmd_count=0 -> done pulses once; pt_ready, core_valid_in and res_valid never assert; busy stays 0.
- Core holds core_in_ready=0 for 5 cycles in ISSUE -> core_valid_in and core_data_in constant for all 6 cycles; exactly one handshake.
- res_ready=0 for 10 cycles in DRAIN -> res_data and res_index stable, pt_ready=0, core_out_ready=0; resumes on res_ready.
- rst_n pulled low during WAIT_OUT -> outputs go to reset values with no clock edge; after release a cmd_count=1 batch completes normally with res_index=0.
- With MSKAES_SVRS_HOST_LATENCY_EN: 46-cycle core -> res_latency=46; core stalled 300 cycles with LAT_W=8 -> res_latency=255.
